// File: rtl/hawk_multich_ctrl_unit_if.sv
// hawk_multich_ctrl_unit_if
// Bundles every non-clock/reset signal of the multi-channel hawk control unit.
//   init_*      : ATT / free-list bring-up handshake
//   req_*       : per-channel CPU requests (channel k at [k*PPN_W +: PPN_W])
//   lkup_*      : ATT lookup request towards the page manager
//   rsp_*       : lookup response from the page manager
//   infl_*      : inflation (decompress) handshake
//   ovrd_*, err_code_o : per-channel result pulses and held PPA
//   busy_o      : controller is not idle in arbitration
// modport master : the control unit
// modport slave  : the surrounding CPU channels / page manager / page writer
interface hawk_multich_ctrl_unit_if #(
    parameter int NUM_CH = 2,
    parameter int PPN_W  = 52
);
    localparam int CH_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;

    logic                      init_att_done_i;
    logic                      init_list_done_i;
    logic                      init_att_o;
    logic                      init_list_o;
    logic [NUM_CH-1:0]         req_valid_i;
    logic [NUM_CH*PPN_W-1:0]   req_hppa_i;
    logic                      lkup_valid_o;
    logic                      lkup_ready_i;
    logic [PPN_W-1:0]          lkup_hppa_o;
    logic [CH_W-1:0]           lkup_ch_o;
    logic                      rsp_valid_i;
    logic                      rsp_allow_i;
    logic                      rsp_infl_i;
    logic [PPN_W-1:0]          rsp_ppa_i;
    logic                      infl_valid_o;
    logic                      infl_ready_i;
    logic                      infl_done_i;
    logic [NUM_CH-1:0]         ovrd_valid_o;
    logic [NUM_CH*PPN_W-1:0]   ovrd_ppa_o;
    logic [NUM_CH-1:0]         ovrd_err_o;
    logic [1:0]                err_code_o;
    logic                      busy_o;

    modport master (
        input  init_att_done_i, init_list_done_i, req_valid_i, req_hppa_i,
               lkup_ready_i, rsp_valid_i, rsp_allow_i, rsp_infl_i, rsp_ppa_i,
               infl_ready_i, infl_done_i,
        output init_att_o, init_list_o, lkup_valid_o, lkup_hppa_o, lkup_ch_o,
               infl_valid_o, ovrd_valid_o, ovrd_ppa_o, ovrd_err_o, err_code_o,
               busy_o
    );

    modport slave (
        output init_att_done_i, init_list_done_i, req_valid_i, req_hppa_i,
               lkup_ready_i, rsp_valid_i, rsp_allow_i, rsp_infl_i, rsp_ppa_i,
               infl_ready_i, infl_done_i,
        input  init_att_o, init_list_o, lkup_valid_o, lkup_hppa_o, lkup_ch_o,
               infl_valid_o, ovrd_valid_o, ovrd_ppa_o, ovrd_err_o, err_code_o,
               busy_o
    );
endinterface

// File: rtl/hawk_multich_ctrl_unit.sv
// hawk_multich_ctrl_unit
// Brings up the ATT and free lists, then serves NUM_CH CPU request channels
// round-robin. Each grant performs an ATT lookup, optionally retried through
// inflation, and ends in a one-cycle per-channel success or error pulse.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : hawk_multich_ctrl_unit_if.master (all request/lookup/result signals)
//
// state     | meaning
// ----------+---------------------------------------------------
// INIT      | waiting for ATT and list init done
// ARB       | idle, round-robin search for a requesting channel
// LKP_REQ   | lookup request presented, waiting for ready
// WAIT_RSP  | waiting for lookup response, timeout running
// INFL_REQ  | inflation request presented, waiting for ready
// INFL_WAIT | waiting for inflation completion
// RELEASE   | one-cycle result pulse, then back to ARB
module hawk_multich_ctrl_unit #(
    parameter int NUM_CH    = 2,
    parameter int PPN_W     = 52,
    parameter int TIMEOUT   = 1024,
    parameter int MAX_RETRY = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    hawk_multich_ctrl_unit_if.master bus
);
    localparam int CH_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;
    localparam int TM_W = $clog2(TIMEOUT);
    localparam int RT_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_INIT, S_ARB, S_LKP_REQ, S_WAIT_RSP, S_INFL_REQ, S_INFL_WAIT, S_RELEASE
    } state_t;

    state_t                  state_q;
    logic                    init_att_q, init_list_q, busy_q;
    logic                    lkup_valid_q, infl_valid_q;
    logic [CH_W-1:0]         ptr_q, ch_q;
    logic [PPN_W-1:0]        hppa_q;
    logic [RT_W-1:0]         retry_q;
    logic [TM_W-1:0]         timer_q;
    logic [NUM_CH-1:0]       ovrd_valid_q, ovrd_err_q;
    logic [1:0]              err_code_q;
    logic [NUM_CH*PPN_W-1:0] ovrd_ppa_q;

    logic                    arb_hit_d;
    logic [CH_W-1:0]         arb_ch_d, ptr_d;
    logic [PPN_W-1:0]        arb_hppa_d;
    logic [NUM_CH-1:0]       ch_oh;
    logic                    att_seen, list_seen;
    int                      idx;

    // Search offsets from the highest down so the closest channel to ptr
    // is the one left standing.
    always_comb begin
        arb_hit_d = 1'b0;
        arb_ch_d  = '0;
        idx       = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (bus.req_valid_i[idx]) begin
                arb_hit_d = 1'b1;
                arb_ch_d  = CH_W'(idx);
            end
        end
        arb_hppa_d = bus.req_hppa_i[int'(arb_ch_d)*PPN_W +: PPN_W];
        ptr_d      = (int'(arb_ch_d) == NUM_CH - 1) ? '0 : arb_ch_d + 1'b1;
    end

    assign ch_oh     = {{(NUM_CH-1){1'b0}}, 1'b1} << ch_q;
    assign att_seen  = bus.init_att_done_i || !init_att_q;
    assign list_seen = bus.init_list_done_i || !init_list_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_INIT;
            init_att_q   <= 1'b1;
            init_list_q  <= 1'b1;
            busy_q       <= 1'b1;
            lkup_valid_q <= 1'b0;
            infl_valid_q <= 1'b0;
            ptr_q        <= '0;
            ch_q         <= '0;
            hppa_q       <= '0;
            retry_q      <= '0;
            timer_q      <= '0;
            ovrd_valid_q <= '0;
            ovrd_err_q   <= '0;
            err_code_q   <= 2'b00;
            ovrd_ppa_q   <= '0;
        end else begin
            // Result pulses last exactly the RELEASE cycle.
            ovrd_valid_q <= '0;
            ovrd_err_q   <= '0;
            err_code_q   <= 2'b00;
            case (state_q)
                S_INIT: begin
                    if (bus.init_att_done_i)  init_att_q  <= 1'b0;
                    if (bus.init_list_done_i) init_list_q <= 1'b0;
                    if (att_seen && list_seen) begin
                        state_q <= S_ARB;
                        busy_q  <= 1'b0;
                    end
                end
                S_ARB: begin
                    if (arb_hit_d) begin
                        ch_q         <= arb_ch_d;
                        hppa_q       <= arb_hppa_d;
                        retry_q      <= '0;
                        ptr_q        <= ptr_d;
                        lkup_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_LKP_REQ;
                    end
                end
                S_LKP_REQ: begin
                    if (bus.lkup_ready_i) begin
                        lkup_valid_q <= 1'b0;
                        timer_q      <= '0;
                        state_q      <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    // A response always beats a timeout landing on the same cycle.
                    if (bus.rsp_valid_i) begin
                        if (bus.rsp_allow_i) begin
                            ovrd_ppa_q[int'(ch_q)*PPN_W +: PPN_W] <= bus.rsp_ppa_i;
                            ovrd_valid_q <= ch_oh;
                            state_q      <= S_RELEASE;
                        end else if (bus.rsp_infl_i && (retry_q < RT_W'(MAX_RETRY))) begin
                            infl_valid_q <= 1'b1;
                            state_q      <= S_INFL_REQ;
                        end else begin
                            ovrd_err_q <= ch_oh;
                            err_code_q <= bus.rsp_infl_i ? 2'b11 : 2'b01;
                            state_q    <= S_RELEASE;
                        end
                    end else if (timer_q == TM_W'(TIMEOUT - 1)) begin
                        ovrd_err_q <= ch_oh;
                        err_code_q <= 2'b10;
                        state_q    <= S_RELEASE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_INFL_REQ: begin
                    if (bus.infl_ready_i) begin
                        infl_valid_q <= 1'b0;
                        state_q      <= S_INFL_WAIT;
                    end
                end
                S_INFL_WAIT: begin
                    if (bus.infl_done_i) begin
                        retry_q      <= retry_q + 1'b1;
                        lkup_valid_q <= 1'b1;
                        state_q      <= S_LKP_REQ;
                    end
                end
                S_RELEASE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_ARB;
                end
                default: begin
                    busy_q  <= 1'b1;
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign bus.init_att_o   = init_att_q;
    assign bus.init_list_o  = init_list_q;
    assign bus.busy_o       = busy_q;
    assign bus.lkup_valid_o = lkup_valid_q;
    assign bus.lkup_hppa_o  = hppa_q;
    assign bus.lkup_ch_o    = ch_q;
    assign bus.infl_valid_o = infl_valid_q;
    assign bus.ovrd_valid_o = ovrd_valid_q;
    assign bus.ovrd_err_o   = ovrd_err_q;
    assign bus.err_code_o   = err_code_q;
    assign bus.ovrd_ppa_o   = ovrd_ppa_q;
endmodule

// File: doc/hawk_multich_ctrl_unit.md
# hawk_multich_ctrl_unit

Parametrised successor to the hawk control unit. Brings up the ATT and free lists after reset, then serves NUM_CH CPU request channels with a fair round-robin arbiter. Each granted request drives one ATT lookup through the page manager and retries through an inflation (decompress) handshake. The block returns a per-channel override pulse carrying the translated PPA, or an error pulse with a cause code. It sits between the CPU interface channels and the page read manager / page writer.

## Interface
- NUM_CH, 2: number of CPU request channels (≥2); CH_W = max(1, $clog2(NUM_CH)).
- PPN_W, 52: page-number width (`HACD_AXI4_ADDR_WIDTH-12).
- TIMEOUT, 1024: max cycles in WAIT_RSP before timeout error (≥2).
- MAX_RETRY, 2: max inflation retries per request (≥1); RT_W = $clog2(MAX_RETRY+1).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- init_att_done_i  in  1  ATT init complete (pulse or level).
- init_list_done_i  in  1  list init complete (pulse or level).
- init_att_o  out  1  ATT init request.
- init_list_o  out  1  list init request.
- req_valid_i  in  NUM_CH  per-channel request; held until that channel's ovrd_valid_o or ovrd_err_o.
- req_hppa_i  in  NUM_CH*PPN_W  per-channel host page; channel k is at [k*PPN_W +: PPN_W].
- lkup_valid_o  out  1  lookup request.
- lkup_ready_i  in  1  page manager ready.
- lkup_hppa_o  out  PPN_W  page to look up.
- lkup_ch_o  out  CH_W  granted channel.
- rsp_valid_i  in  1  lookup response strobe.
- rsp_allow_i  in  1  access allowed.
- rsp_infl_i  in  1  page compressed; needs inflation.
- rsp_ppa_i  in  PPN_W  translated page.
- infl_valid_o  out  1  inflation request.
- infl_ready_i  in  1  inflation accepted.
- infl_done_i  in  1  inflation complete.
- ovrd_valid_o  out  NUM_CH  one-cycle grant pulse per channel.
- ovrd_ppa_o  out  NUM_CH*PPN_W  per-channel PPA; held until that channel's next success.
- ovrd_err_o  out  NUM_CH  one-cycle error pulse per channel.
- err_code_o  out  2  01 deny, 10 timeout, 11 retry exhausted; valid with ovrd_err_o, else 00.
- busy_o  out  1  high in every state except ARB.

## Operation

States: INIT, ARB, LKP_REQ, WAIT_RSP, INFL_REQ, INFL_WAIT, RELEASE.

- **INIT**
  - init_att_o and init_list_o are each cleared, sticky, the cycle after their done input is first seen.
  - Done inputs may arrive in either order or together.
  - Exit to ARB once both have been seen (the cycle both outputs read 0).
- **ARB**
  - Round-robin pointer ptr starts at 0.
  - Grant the first channel with req_valid_i set, searching ptr, ptr+1, … mod NUM_CH.
  - On grant: latch ch and hppa, clear retry_cnt, set ptr = (ch+1) mod NUM_CH, go to LKP_REQ.
  - No request: stay in ARB.
- **LKP_REQ**
  - lkup_valid_o = 1 with the latched hppa and ch.
  - On lkup_ready_i: go to WAIT_RSP and clear the timer.
- **WAIT_RSP**
  - rsp_valid_i is sampled only in this state and ignored elsewhere.
  - rsp_allow_i = 1 (wins over rsp_infl_i): write ovrd_ppa[ch] = rsp_ppa_i, go to RELEASE (success).
  - rsp_infl_i = 1 only: if retry_cnt < MAX_RETRY, go to INFL_REQ; otherwise RELEASE with error 11.
  - Neither flag set: RELEASE with error 01.
  - Timer counts each cycle without a response. When it reaches TIMEOUT-1, go to RELEASE with error 10.
  - A response in the same cycle as the timeout wins.
- **INFL_REQ**
  - infl_valid_o = 1 with lkup_hppa_o unchanged.
  - On infl_ready_i: go to INFL_WAIT.
- **INFL_WAIT**
  - On infl_done_i: retry_cnt += 1, go to LKP_REQ.
- **RELEASE** (one cycle)
  - Exactly one of ovrd_valid_o[ch] or ovrd_err_o[ch] = 1.
  - Next state is always ARB.
  - This extra cycle gives the requester time to drop req_valid_i, so the same request is never re-granted.

## Timing
- **Reset values (outputs):** init_att_o = init_list_o = 1; busy_o = 1 (state INIT); all other outputs 0, including ovrd_ppa_o.
- **Reset values (internal):** ptr = 0, retry_cnt = 0, timer = 0.
- **Reset mid-operation:** abort any lookup or inflation immediately, return to INIT, re-assert both init outputs. No pulse is emitted.
- **Output decode:** all outputs are registered or decoded from registered state and latches; no combinational path from inputs to outputs.
- **Minimum latency:**
  - Request sampled in ARB at cycle 0.
  - lkup_valid_o at cycle 1; with lkup_ready_i, in WAIT_RSP at cycle 2.
  - Response at cycle 2 gives the ovrd_valid_o pulse at cycle 3 and ARB at cycle 4.
- **Handshakes:** lkup_valid_o and infl_valid_o stay stable, with constant payload, until accepted.
- **Widths:**
  - Timer width is $clog2(TIMEOUT); it does not wrap.
  - Pointer increment wraps modulo NUM_CH, including non-power-of-2 values.

## Test plan
1. **Init ordering.** Reset, then list_done at cycle 5 and att_done at cycle 9. Required: init_list_o falls at 6, init_att_o at 10, busy_o low (ARB) at 10. Repeat with both done inputs in the same cycle.
2. **Fairness.** NUM_CH=3, all channels hold requests, immediate ready and allow with rsp_ppa = 0x100 + ch. Required: grant order 0,1,2,0; each ovrd_ppa_o slot = 0x100 + ch; pulses exactly 4 cycles apart.
3. **Inflation.** One inflate response, then allow with ppa 0xABC. Required: one infl_valid_o handshake with the same hppa; lookup re-issued after infl_done_i; ovrd_valid_o with ppa 0xABC.
4. **Retry exhaustion.** MAX_RETRY = 2, three consecutive inflate responses. Required: 2 inflations, then ovrd_err_o with err_code_o = 11.
5. **Timeout and deny.**
   - TIMEOUT = 8, no response: error 10 exactly 8 cycles after WAIT_RSP entry.
   - Response arriving on that same cycle: success instead of error.
   - rsp_valid_i with allow = infl = 0: error 01.
6. **Reset mid-operation.** Assert rst_i in INFL_WAIT. Required: no pulses; init outputs re-assert next cycle; ptr restarts at 0.
